z_pc_unit: RTL
==============

# z_pc_unit

Registered fetch-address generator for the pipelined MIPS core, in front of the instruction memory port. It holds the architectural fetch PC and issues fetch requests with a valid/ready handshake. It applies stalls and redirects (branch, jump, jump-register, exception) with fixed priority. Redirects that arrive while a fetch is outstanding are deferred and that fetch is squashed.

## Interface
- `WIDTH`, 32, address width; WIDTH ≥ 32.
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset.
- `EXC_VECTOR`, 32'h8000_0180, exception handler address.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the PC; no new request is issued.
- `redir_valid`  in  1  a redirect qualifier set is valid this cycle.
- `jump`, `branch`, `zero`, `jr`, `exc`  in  1 each  redirect qualifiers.
- `redir_pc`  in  WIDTH  PC of the redirecting instruction.
- `redir_inst`  in  32  the redirecting instruction word.
- `jr_target`  in  WIDTH  register value for `jr`.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  WIDTH  fetch address.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `fetch_pc`  out  WIDTH  address of the last granted fetch.
- `fetch_valid`  out  1  one-cycle pulse: the last grant is to be used.
- `fetch_kill`  out  1  one-cycle pulse: the last grant is squashed.
- `epc`  out  WIDTH  `redir_pc` captured on exception.
- `misalign`  out  1  misaligned-target trap pulse (only with `PC_ALIGN_CHK_EN`).

## Operation
- Target arithmetic, with `rinc = redir_pc + 4` (mod 2^WIDTH):
  - jump target = `{rinc[WIDTH-1:28], redir_inst[25:0], 2'b00}`.
  - branch target = `rinc + (sext(redir_inst[15:0]) << 2)`, computed at WIDTH bits with wrap.
  - sequential = `pc + 4`, wrapping.
- Redirect priority when `redir_valid`: `exc` > `jr` > `jump` > (`branch && zero`) > none.
  - `branch` with `zero=0` is no redirect.
  - Redirect qualifiers are ignored when `redir_valid=0`.
- States:
  - RST: entered on reset. `imem_req=0`. Moves to RUN on the first clock after `rst_n` deasserts.
  - RUN: `imem_req = !stall`.
  - PEND: a redirect is latched while a request is outstanding. `imem_req` stays 1 and `imem_addr` stays stable.
- RUN transitions:
  - Redirect with no outstanding request (`imem_req=0`, or `imem_gnt=1` this cycle): pc ← target next cycle. A grant in the same cycle produces `fetch_kill`.
  - Redirect with `imem_req=1 && imem_gnt=0`: latch the target, go to PEND.
  - Grant without redirect and `!stall`: pc ← sequential; `fetch_valid` pulses next cycle.
- PEND transitions:
  - On `imem_gnt`: `fetch_kill` pulses next cycle, pc ← pending target, return to RUN.
  - A newer redirect while in PEND replaces the pending target. Priority rules apply against the pending entry; `exc` always wins.
- `stall` does not deassert an already-asserted unaccepted request. Valid/ready rule: once `imem_req=1`, `imem_addr` must not change until `imem_gnt`.
- Exception: `epc ← redir_pc` on acceptance of an `exc` redirect.
- Reset values: pc = RESET_VECTOR, state RST, `imem_req=0`, `fetch_pc=RESET_VECTOR`, `fetch_valid=0`, `fetch_kill=0`, `epc=0`, `misalign=0`, pending target cleared.

## Timing
- All outputs are registered except `imem_req`, which is decoded from state and `stall`. `imem_addr` = pc register.
- Redirect to new `imem_addr`: 1 cycle when no request is outstanding; otherwise 1 cycle after the pending grant.
- `fetch_valid`/`fetch_kill` appear the cycle after the grant; they are mutually exclusive.
- Asserting `rst_n` low mid-operation clears state immediately. Any outstanding request is abandoned with no kill pulse.

## Configuration
- `PC_ALIGN_CHK_EN` defined: any jr/jump/branch target with bits [1:0] ≠ 0 is replaced by an exception.
  - pc ← EXC_VECTOR, `epc ← redir_pc`.
  - `misalign` pulses one cycle, in the same cycle pc takes EXC_VECTOR.
- `PC_ALIGN_CHK_EN` undefined: targets are used unchanged, and `misalign` is tied 0.

## Test plan
- Reset release with RESET_VECTOR=0 and `imem_gnt=1` held → addr 0, 4, 8 on consecutive cycles; `fetch_valid` each cycle after the first grant.
- Branch: `redir_pc=0x100`, inst offset 0xFFFF, `branch=zero=1`, no outstanding request → next `imem_addr=0x100`. With `zero=0` → sequential.
- Jump: `redir_pc=0x1000_0040`, inst[25:0]=0x0000010 → `imem_addr=0x1000_0040`. A same-cycle `jr` with `jr_target=0x200` wins → 0x200.
- Redirect during stalled grant: `imem_req=1`, `imem_gnt=0` for 3 cycles at addr 0x20, then jump to 0x400 → addr holds at 0x20 until grant; then `fetch_kill` pulses and the next addr is 0x400.
- `exc` together with `jump` at `redir_pc=0x88` → addr EXC_VECTOR, `epc=0x88`. Reset asserted mid-PEND → addr 0, `fetch_kill=0`.
- With `PC_ALIGN_CHK_EN`: `jr_target=0x202` → `misalign` pulse, addr 0x8000_0180. Without the macro → addr 0x202.

Source files
------------

// File: rtl/z_pc_unit_if.sv
// Instruction-memory fetch port: request/address from the PC unit, grant from memory.
interface z_pc_unit_if #(
   parameter int WIDTH = 32
);
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_gnt;

   modport master (output imem_req, output imem_addr, input imem_gnt);
   modport slave  (input imem_req, input imem_addr, output imem_gnt);
endinterface

// File: rtl/z_pc_unit.sv
// Fetch-address generator: holds the fetch PC, issues valid/ready fetches, applies prioritised redirects.
// Optional PC_ALIGN_CHK_EN turns misaligned jr/jump/branch targets into an exception with a misalign pulse.
module z_pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_stall,
   input  logic             i_redir_valid,
   input  logic             i_jump,
   input  logic             i_branch,
   input  logic             i_zero,
   input  logic             i_jr,
   input  logic             i_exc,
   input  logic [WIDTH-1:0] i_redir_pc,
   input  logic [31:0]      i_redir_inst,
   input  logic [WIDTH-1:0] i_jr_target,
   z_pc_unit_if.master      imem,
   output logic [WIDTH-1:0] o_fetch_pc,
   output logic             o_fetch_valid,
   output logic             o_fetch_kill,
   output logic [WIDTH-1:0] o_epc,
   output logic             o_misalign
);

   localparam logic [1:0] ST_RST  = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_pc;
   logic             r_out;
   logic [WIDTH-1:0] r_pend_tgt;
   logic [WIDTH-1:0] r_pend_epc;
   logic             r_pend_exc;
   logic             r_pend_mis;
   logic [WIDTH-1:0] r_fetch_pc;
   logic             r_fetch_valid;
   logic             r_fetch_kill;
   logic [WIDTH-1:0] r_epc;
   logic             r_misalign;

   logic [WIDTH-1:0] w_rinc;
   logic [WIDTH-1:0] w_jmp_tgt;
   logic [WIDTH-1:0] w_br_tgt;
   logic [WIDTH-1:0] w_raw_tgt;
   logic [WIDTH-1:0] w_new_tgt;
   logic             w_hit;
   logic             w_mis;
   logic             w_new_exc;
   logic             w_take_new;
   logic [WIDTH-1:0] w_sel_tgt;
   logic [WIDTH-1:0] w_sel_epc;
   logic             w_sel_exc;
   logic             w_sel_mis;
   logic             w_req;
   logic             w_fire;
   logic             w_unused_inst;

   assign w_rinc    = i_redir_pc + WIDTH'(4);
   assign w_jmp_tgt = {w_rinc[WIDTH-1:28], i_redir_inst[25:0], 2'b00};
   assign w_br_tgt  = w_rinc + {{(WIDTH-18){i_redir_inst[15]}}, i_redir_inst[15:0], 2'b00};
   assign w_hit     = i_redir_valid & (i_exc | i_jr | i_jump | (i_branch & i_zero));
   assign w_unused_inst = ^i_redir_inst[31:26];

   always_comb begin
      w_raw_tgt = w_br_tgt;
      if (i_jr)
         w_raw_tgt = i_jr_target;
      else if (i_jump)
         w_raw_tgt = w_jmp_tgt;
   end

`ifdef PC_ALIGN_CHK_EN
   assign w_mis = w_hit & ~i_exc & (w_raw_tgt[1:0] != 2'b00);
`else
   assign w_mis = 1'b0;
`endif

   assign w_new_exc  = (i_redir_valid & i_exc) | w_mis;
   assign w_new_tgt  = w_new_exc ? EXC_VECTOR : w_raw_tgt;
   // A pending exception can only be displaced by another exception.
   assign w_take_new = w_hit & (w_new_exc | ~r_pend_exc);

   always_comb begin
      w_sel_tgt = w_new_tgt;
      w_sel_epc = i_redir_pc;
      w_sel_exc = w_new_exc;
      w_sel_mis = w_mis;
      if ((r_state == ST_PEND) && !w_take_new) begin
         w_sel_tgt = r_pend_tgt;
         w_sel_epc = r_pend_epc;
         w_sel_exc = r_pend_exc;
         w_sel_mis = r_pend_mis;
      end
   end

   // An unaccepted request stays up through a stall so the address stays committed.
   assign w_req  = (r_state == ST_PEND) | ((r_state == ST_RUN) & (~i_stall | r_out));
   assign w_fire = w_req & imem.imem_gnt;

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_pc;
   assign o_fetch_pc     = r_fetch_pc;
   assign o_fetch_valid  = r_fetch_valid;
   assign o_fetch_kill   = r_fetch_kill;
   assign o_epc          = r_epc;
   assign o_misalign     = r_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RST;
         r_pc          <= RESET_VECTOR;
         r_out         <= 1'b0;
         r_pend_tgt    <= '0;
         r_pend_epc    <= '0;
         r_pend_exc    <= 1'b0;
         r_pend_mis    <= 1'b0;
         r_fetch_pc    <= RESET_VECTOR;
         r_fetch_valid <= 1'b0;
         r_fetch_kill  <= 1'b0;
         r_epc         <= '0;
         r_misalign    <= 1'b0;
      end else begin
         r_fetch_valid <= 1'b0;
         r_fetch_kill  <= 1'b0;
         r_misalign    <= 1'b0;
         if (w_fire)
            r_fetch_pc <= r_pc;
         case (r_state)
            ST_RST: r_state <= ST_RUN;
            ST_RUN: begin
               r_out <= w_req & ~imem.imem_gnt;
               if (w_hit) begin
                  if (w_req & ~imem.imem_gnt) begin
                     r_state    <= ST_PEND;
                     r_pend_tgt <= w_new_tgt;
                     r_pend_epc <= i_redir_pc;
                     r_pend_exc <= w_new_exc;
                     r_pend_mis <= w_mis;
                  end else begin
                     r_pc         <= w_new_tgt;
                     r_misalign   <= w_mis;
                     r_fetch_kill <= w_fire;
                     if (w_new_exc)
                        r_epc <= i_redir_pc;
                  end
               end else if (w_fire) begin
                  r_pc          <= r_pc + WIDTH'(4);
                  r_fetch_valid <= 1'b1;
               end
            end
            ST_PEND: begin
               if (imem.imem_gnt) begin
                  r_pc         <= w_sel_tgt;
                  r_misalign   <= w_sel_mis;
                  r_fetch_kill <= 1'b1;
                  r_state      <= ST_RUN;
                  r_out        <= 1'b0;
                  if (w_sel_exc)
                     r_epc <= w_sel_epc;
               end else if (w_take_new) begin
                  r_pend_tgt <= w_new_tgt;
                  r_pend_epc <= i_redir_pc;
                  r_pend_exc <= w_new_exc;
                  r_pend_mis <= w_mis;
               end
            end
            default: r_state <= ST_RST;
         endcase
      end
   end

endmodule
